// File: rtl/ram_256x2.sv
// 256 x 2-bit simple dual-port RAM with per-entry valid flags and a registered read port.
// Define RAM_256X2_WRITE_FORWARD_EN for write-first collisions; read-first otherwise.
module ram_256x2 #(
    parameter logic [1:0] RESET_VALUE = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [1:0] din,
    input  logic [7:0] raddr,
    output logic [1:0] dout
);

    logic [1:0] mem_reg   [256];
    logic       valid_reg [256];
    logic [1:0] dout_reg;
    logic [1:0] dout_next;
    logic       collide;

    // Data bits are never cleared; the valid flags hide stale contents after reset.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            mem_reg[waddr] <= din;
        end
    end

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                end else if (we && (waddr == 8'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign collide = we && (raddr == waddr);

    always_comb begin
        dout_next = valid_reg[raddr] ? mem_reg[raddr] : RESET_VALUE;
`ifdef RAM_256X2_WRITE_FORWARD_EN
        if (collide) begin
            dout_next = din;
        end
`else
        // Read-first: the array read already returns the pre-write contents.
        if (collide && !valid_reg[raddr]) begin
            dout_next = RESET_VALUE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg <= RESET_VALUE;
        end else begin
            dout_reg <= dout_next;
        end
    end

    assign dout = dout_reg;

endmodule

// File: tb/tb_ram_256x2.sv
// Directed self-checking bench for ram_256x2; expectations follow the build's collision mode.
module tb_ram_256x2;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [7:0] waddr;
    logic [1:0] din;
    logic [7:0] raddr;
    logic [1:0] dout;

    integer checks;
    integer errors;

    ram_256x2 #(.RESET_VALUE(2'b00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .din   (din),
        .raddr (raddr),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 2'b00) begin
            errors++;
            $display("FAIL reset_async dout=%b expected=%b", dout, 2'b00);
        end
        tick();
        rst_n = 1'b1;
        raddr = 8'd0;
        tick();
        tick();
        checks++;
        if (dout !== 2'b00) begin
            errors++;
            $display("FAIL reset_read0 dout=%b expected=%b", dout, 2'b00);
        end
        $display("[%0t] reset: dout=%b", $time, dout);
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 8'd1; din = 2'b01;
        tick();
        we = 1'b0; raddr = 8'd1;
        #1;
        checks++;
        if (dout !== 2'b00) begin
            errors++;
            $display("FAIL latency_hold dout=%b expected=%b", dout, 2'b00);
        end
        tick();
        checks++;
        if (dout !== 2'b01) begin
            errors++;
            $display("FAIL read_addr1 dout=%b expected=%b", dout, 2'b01);
        end
        $display("[%0t] write 1=01 read 1: dout=%b", $time, dout);
        raddr = 8'd0;
        tick();
        checks++;
        if (dout !== 2'b00) begin
            errors++;
            $display("FAIL read_addr0 dout=%b expected=%b", dout, 2'b00);
        end
        $display("[%0t] read 0: dout=%b", $time, dout);
    endtask

    task automatic test_no_corruption();
        we = 1'b1; waddr = 8'd2; din = 2'b10;
        tick();
        we = 1'b0; raddr = 8'd2;
        tick();
        checks++;
        if (dout !== 2'b10) begin
            errors++;
            $display("FAIL read_addr2 dout=%b expected=%b", dout, 2'b10);
        end
        raddr = 8'd1;
        tick();
        checks++;
        if (dout !== 2'b01) begin
            errors++;
            $display("FAIL reread_addr1 dout=%b expected=%b", dout, 2'b01);
        end
        $display("[%0t] write 2=10, reread 1: dout=%b", $time, dout);
    endtask

    task automatic test_reset_clear();
        we = 1'b1; waddr = 8'd5; din = 2'b11;
        tick();
        we = 1'b0; raddr = 8'd5;
        tick();
        checks++;
        if (dout !== 2'b11) begin
            errors++;
            $display("FAIL read_addr5 dout=%b expected=%b", dout, 2'b11);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 2'b00) begin
            errors++;
            $display("FAIL reset_midcycle dout=%b expected=%b", dout, 2'b00);
        end
        we = 1'b1; waddr = 8'd6; din = 2'b11;
        tick();
        we = 1'b0;
        rst_n = 1'b1;
        raddr = 8'd5;
        tick();
        checks++;
        if (dout !== 2'b00) begin
            errors++;
            $display("FAIL cleared_addr5 dout=%b expected=%b", dout, 2'b00);
        end
        raddr = 8'd6;
        tick();
        checks++;
        if (dout !== 2'b00) begin
            errors++;
            $display("FAIL ignored_write6 dout=%b expected=%b", dout, 2'b00);
        end
        $display("[%0t] reset clear: addr5/addr6 read %b", $time, dout);
    endtask

    task automatic test_collision();
        logic [1:0] exp_hit;
        logic [1:0] exp_new;
`ifdef RAM_256X2_WRITE_FORWARD_EN
        exp_hit = 2'b10;
        exp_new = 2'b11;
`else
        exp_hit = 2'b01;
        exp_new = 2'b00;
`endif
        we = 1'b1; waddr = 8'd7; din = 2'b01;
        tick();
        din = 2'b10; raddr = 8'd7;
        tick();
        checks++;
        if (dout !== exp_hit) begin
            errors++;
            $display("FAIL collide_written dout=%b expected=%b", dout, exp_hit);
        end
        we = 1'b0;
        tick();
        checks++;
        if (dout !== 2'b10) begin
            errors++;
            $display("FAIL collide_after dout=%b expected=%b", dout, 2'b10);
        end
        we = 1'b1; waddr = 8'd9; raddr = 8'd9; din = 2'b11;
        tick();
        checks++;
        if (dout !== exp_new) begin
            errors++;
            $display("FAIL collide_unwritten dout=%b expected=%b", dout, exp_new);
        end
        we = 1'b0;
        tick();
        checks++;
        if (dout !== 2'b11) begin
            errors++;
            $display("FAIL collide_unwritten_after dout=%b expected=%b", dout, 2'b11);
        end
        $display("[%0t] collision: addr7=%b addr9=%b", $time, exp_hit, dout);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            we = 1'b1; waddr = a; din = a[1:0];
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            raddr = a;
            tick();
            checks++;
            if (dout !== a[1:0]) begin
                errors++;
                $display("FAIL sweep addr=%0d dout=%b expected=%b", i, dout, a[1:0]);
            end
            $display("[%0t] sweep read %0d: dout=%b", $time, i, dout);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        we = 1'b0; waddr = 8'd0; din = 2'b00; raddr = 8'd0;
        test_reset();
        test_write_read();
        test_no_corruption();
        test_reset_clear();
        test_collision();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_256x2.md
RAM_256X2 -- requirements
Module: ram_256x2

Interface
REQ-001 The block SHALL have parameter RESET_VALUE, default 2'b00: the value returned for any unwritten or reset-cleared location, and dout's reset value.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all sampling is on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port we, input, 1 bit: write enable.
REQ-005 The block SHALL have port waddr, input, 8 bits: write address.
REQ-006 The block SHALL have port din, input, 2 bits: write data.
REQ-007 The block SHALL have port raddr, input, 8 bits: read address, independent of waddr.
REQ-008 The block SHALL have port dout, output, 2 bits: registered read data.

Function
REQ-009 The block SHALL be a 256-entry x 2-bit simple dual-port RAM: one write port and one read port, both synchronous to clk.
REQ-010 On a rising clk edge with we=1 and rst_n=1, the block SHALL store din at waddr; with we=0, storage is unchanged.
REQ-011 Each entry SHALL carry a valid flag, set by a write to that entry and cleared by reset.
REQ-012 On every rising clk edge with rst_n=1, dout SHALL load the contents of raddr if its valid flag is set, else RESET_VALUE.
REQ-013 Read latency SHALL be exactly one clock: a raddr change is reflected on dout after the next rising edge; dout holds between edges.
REQ-014 There SHALL be no read enable: dout is updated every cycle.
REQ-015 A read of an address written in a prior cycle SHALL return that written data.
REQ-016 Writing an address SHALL not affect any other address.
REQ-017 Address space SHALL be exactly 256 entries; there is no out-of-range condition and no wrap logic.
REQ-018 A simultaneous read and write to the same address in one cycle SHALL follow REQ-027/REQ-028.
REQ-019 Writes to different addresses in consecutive cycles SHALL each complete in one cycle, with no stall.

Reset
REQ-020 rst_n=0 SHALL immediately, with no clock required, force dout to RESET_VALUE.
REQ-021 rst_n=0 SHALL immediately clear all 256 valid flags.
REQ-022 While rst_n=0, the block SHALL ignore writes.
REQ-023 Stored data bits SHALL not need to be cleared; reads return RESET_VALUE through the valid flags.
REQ-024 After rst_n deasserts, the first rising edge SHALL perform normal read and write operation.
REQ-025 Reset asserted mid-operation SHALL discard any write sampled on that edge.

Configuration
REQ-026 The macro RAM_256X2_WRITE_FORWARD_EN SHALL select same-address collision behaviour.
REQ-027 With RAM_256X2_WRITE_FORWARD_EN defined: on an edge with we=1 and raddr==waddr, dout SHALL load din (write-first).
REQ-028 With RAM_256X2_WRITE_FORWARD_EN undefined: on an edge with we=1 and raddr==waddr, dout SHALL load the pre-write contents of that address, or RESET_VALUE if unwritten (read-first).

Verification
REQ-029 Reset, then raddr=0 for 2 cycles -> dout=RESET_VALUE (2'b00).
REQ-030 we=1, waddr=1, din=1 for one edge; then we=0, raddr=1 -> dout=2'b01 one edge later; raddr=0 -> dout=2'b00.
REQ-031 we=1, waddr=2, din=2; then we=0, raddr=2 -> dout=2'b10; re-read address 1 -> dout=2'b01 (no corruption).
REQ-032 Write address 5 = 3, assert rst_n=0 between edges -> dout=2'b00 immediately; after release, read 5 -> 2'b00.
REQ-033 Address 7 holds 1; same cycle we=1, waddr=7, raddr=7, din=2 -> dout=2 with RAM_256X2_WRITE_FORWARD_EN, dout=1 without; next edge dout=2 in both builds.
REQ-034 Write all 256 addresses with addr[1:0], then read back sequentially -> each dout equals addr[1:0] one cycle after its raddr.
